// File: rtl/sparse_index_feeder.sv
// Sparse-term index feeder: latches a packed key word and streams its indices over valid/ready.
// Build macro DUMMY_INSERT_EN adds LFSR-generated dummy indices flagged on idx_dummy_o.
module sparse_index_feeder #(
   parameter int          IDX_W     = 16,
   parameter int          NUM_IDX   = 8,
   parameter int          POLY_N    = 12323,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     load_i,
   input  logic [IDX_W*NUM_IDX-1:0] key_i,
   output logic [IDX_W-1:0]         idx_o,
   output logic                     idx_valid_o,
   input  logic                     idx_ready_i,
   output logic                     idx_dummy_o,
   output logic                     idx_last_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o
);

   localparam int               SLOT_W    = (NUM_IDX > 1) ? $clog2(NUM_IDX) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_IDX - 1);
   localparam logic [IDX_W-1:0]  POLY_LIM  = IDX_W'(POLY_N);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REAL  = 2'd1,
      S_DONE  = 2'd2
`ifdef DUMMY_INSERT_EN
      ,S_DUMMY = 2'd3
`endif
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [SLOT_W-1:0]        r_slot;
   logic [SLOT_W-1:0]        w_slot_nxt;
   logic                     r_err;
   logic                     w_err_nxt;
   logic [IDX_W*NUM_IDX-1:0] r_key;
   logic                     w_key_ld;
   logic                     w_pick;
   logic [IDX_W-1:0]         w_field [NUM_IDX];

   for (genvar g = 0; g < NUM_IDX; g++) begin : g_field
      assign w_field[g] = r_key[g*IDX_W +: IDX_W];
   end

`ifdef DUMMY_INSERT_EN
   localparam int FOLD_STEPS = ((2 ** IDX_W) - 1) / POLY_N;

   logic [15:0]      r_lfsr;
   logic             w_lfsr_fb;
   logic [IDX_W-1:0] r_dval;

   // Repeated subtraction so any raw LFSR sample lands on a legal index.
   function automatic logic [IDX_W-1:0] f_fold(input logic [IDX_W-1:0] v);
      logic [IDX_W-1:0] r;
      r = v;
      for (int i = 0; i < FOLD_STEPS; i++) begin
         if (r >= POLY_LIM) r = r - POLY_LIM;
      end
      return r;
   endfunction

   // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
   assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

   always_ff @(posedge clk) begin
      if (!resetn) r_lfsr <= LFSR_SEED;
      else         r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
   end

   always_ff @(posedge clk) begin
      if (w_pick) r_dval <= f_fold(r_lfsr[IDX_W-1:0]);
   end
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_slot  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_slot  <= w_slot_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_key_ld) r_key <= key_i;
   end

   // w_pick marks the combinational PICK step: a new slot is about to be presented.
   always_comb begin
      w_state_nxt = r_state;
      w_slot_nxt  = r_slot;
      w_err_nxt   = r_err;
      w_key_ld    = 1'b0;
      w_pick      = 1'b0;
      idx_o       = '0;
      idx_valid_o = 1'b0;
      idx_dummy_o = 1'b0;
      idx_last_o  = 1'b0;
      busy_o      = 1'b1;
      done_o      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (load_i) begin
               w_key_ld   = 1'b1;
               w_err_nxt  = 1'b0;
               w_slot_nxt = '0;
               w_pick     = 1'b1;
            end
         end
`ifdef DUMMY_INSERT_EN
         S_DUMMY: begin
            idx_valid_o = 1'b1;
            idx_dummy_o = 1'b1;
            idx_o       = r_dval;
            if (idx_ready_i) w_state_nxt = S_REAL;
         end
`endif
         S_REAL: begin
            idx_valid_o = 1'b1;
            idx_o       = w_field[r_slot];
            idx_last_o  = (r_slot == LAST_SLOT);
            if (idx_ready_i) begin
               if (w_field[r_slot] >= POLY_LIM) w_err_nxt = 1'b1;
               if (r_slot == LAST_SLOT) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_slot_nxt = r_slot + SLOT_W'(1);
                  w_pick     = 1'b1;
               end
            end
         end
         S_DONE: begin
            done_o      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_pick) begin
`ifdef DUMMY_INSERT_EN
         w_state_nxt = r_lfsr[0] ? S_DUMMY : S_REAL;
`else
         w_state_nxt = S_REAL;
`endif
      end
   end

   assign err_o = r_err;

   a_seed_nonzero: assert property (@(posedge clk) LFSR_SEED != 16'd0);
   a_hold_stalled: assert property (@(posedge clk) disable iff (!resetn)
      (idx_valid_o && !idx_ready_i) |=> (idx_valid_o && $stable(idx_o) &&
                                         $stable(idx_dummy_o) && $stable(idx_last_o)));
   a_dummy_not_last: assert property (@(posedge clk) !(idx_last_o && idx_dummy_o));

endmodule
